// File: rtl/aes_pkg.sv
// Shared AES-256 inverse cipher definitions: sizes, FSM encoding,
// inverse S-box table and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_DATA_LEN      = 128;
  localparam int AES_NUMS_OF_ROUND = 14;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    LAST
  } fsm_e;

  // Byte n of the table sits at index n (MSB-first packing)
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row r rotates right by r; byte i = row (i%4), column (i/4)
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r)&3)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      o[119-32*c -: 8] = mul9(a0) ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      o[111-32*c -: 8] = mul13(a0) ^ mul9(a1) ^ mul14(a2) ^ mul11(a3);
      o[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2) ^ mul14(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_if.sv
// Key/ciphertext/plaintext handshake bundle for the inverse cipher.
interface aes_inv_if
  import aes_pkg::*;
#(
  parameter int DATA_LEN      = AES_DATA_LEN,
  parameter int NUMS_OF_ROUND = AES_NUMS_OF_ROUND
);

  logic                                  key_valid_in;
  logic [(NUMS_OF_ROUND+1)*DATA_LEN-1:0] round_keys;
  logic                                  data_valid_in;
  logic                                  data_ready_out;
  logic [DATA_LEN-1:0]                   cipher_text;
  logic                                  data_valid_out;
  logic [DATA_LEN-1:0]                   plain_text;

  modport master (
    output key_valid_in, round_keys,
    output data_valid_in, cipher_text,
    input  data_ready_out,
    input  data_valid_out, plain_text
  );

  modport slave (
    input  key_valid_in, round_keys,
    input  data_valid_in, cipher_text,
    output data_ready_out,
    output data_valid_out, plain_text
  );

endinterface

// File: rtl/aes_inv_cipher_inv_sbox.sv
// Single-byte inverse S-box lookup, purely combinational.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  assign result = INV_SBOX[value];

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-256 inverse cipher, one round per clock,
// with a captured key schedule and a 15-cycle block turnaround.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int DATA_LEN      = AES_DATA_LEN,
  parameter int NUMS_OF_ROUND = AES_NUMS_OF_ROUND
) (
  input logic      clk,
  input logic      reset,
  aes_inv_if.slave bus
);

  localparam int KEYS_W = (NUMS_OF_ROUND + 1) * DATA_LEN;
  localparam int CNT_W  = $clog2(NUMS_OF_ROUND + 1);
  localparam int NB     = DATA_LEN / 8;

  fsm_e                fsm_q, fsm_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_LEN-1:0] state_q;
  logic [DATA_LEN-1:0] text_q;
  logic                valid_q;
  logic                key_loaded_q;
  logic [KEYS_W-1:0]   key_q;

  logic                key_load;
  logic                ready;
  logic                accept;
  logic [DATA_LEN-1:0] sr, sb, rk;

  assign key_load = (fsm_q == IDLE) && bus.key_valid_in;
  assign ready    = (fsm_q == IDLE) && key_loaded_q
                    && !bus.key_valid_in;
  assign accept   = ready && bus.data_valid_in;

  assign bus.data_ready_out = ready;
  assign bus.data_valid_out = valid_q;
  assign bus.plain_text     = text_q;

  // Shared front half of every round; LAST just skips InvMixColumns
  assign sr = inv_shift_rows(state_q);
  assign rk = key_q[int'(cnt_q)*DATA_LEN +: DATA_LEN];

  for (genvar i = 0; i < NB; i++) begin : g_sbox
    inv_sbox u_sbox (
      .value  (sr[DATA_LEN-1-8*i -: 8]),
      .result (sb[DATA_LEN-1-8*i -: 8])
    );
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (accept) fsm_d = ROUND;
      ROUND:   if (cnt_q == CNT_W'(1)) fsm_d = LAST;
      LAST:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= IDLE;
      cnt_q        <= '0;
      state_q      <= '0;
      text_q       <= '0;
      valid_q      <= 1'b0;
      key_loaded_q <= 1'b0;
      key_q        <= '0;
    end else begin
      fsm_q   <= fsm_d;
      valid_q <= 1'b0;
      if (key_load) begin
        key_q        <= bus.round_keys;
        key_loaded_q <= 1'b1;
      end
      unique case (fsm_q)
        IDLE: begin
          if (accept) begin
            state_q <= bus.cipher_text
                       ^ key_q[NUMS_OF_ROUND*DATA_LEN +: DATA_LEN];
            cnt_q   <= CNT_W'(NUMS_OF_ROUND - 1);
          end
        end
        ROUND: begin
          state_q <= inv_mix_columns(sb ^ rk);
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        LAST: begin
          text_q  <= sb ^ key_q[DATA_LEN-1:0];
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Directed and round-trip checks for aes_inv_cipher against an
// independent forward AES-256 model.
module tb_aes_inv_cipher;

  logic clk;
  logic reset;

  aes_inv_if #(.DATA_LEN(128), .NUMS_OF_ROUND(14)) bus ();

  aes_inv_cipher #(.DATA_LEN(128), .NUMS_OF_ROUND(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]    sbox [256];
  logic [1919:0] keys_a, alt_keys, rk;
  logic [127:0]  pt, ct, pt_x, pt_y;
  logic [127:0]  bb_pt [3];
  logic [127:0]  bb_ct [3];
  int            acc [3];
  int            nacc, nres, busy, cnt_r, cnt_v;

  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Forward S-box from field inverse plus affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++)
      o[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p,
                                           input logic [1919:0] k);
    logic [127:0] s, t;
    s = p ^ k[127:0];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox[s[127-8*i -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[127-8*(r+4*c) -: 8] = t[127-8*(r+4*((c+r)%4)) -: 8];
      if (rnd < 14) s = mix_columns(s);
      s = s ^ k[128*rnd +: 128];
    end
    return s;
  endfunction

  task automatic load_key(input logic [1919:0] k);
    bus.round_keys   = k;
    bus.key_valid_in = 1'b1;
    tick();
    bus.key_valid_in = 1'b0;
  endtask

  // One block: wait ready, accept, time the result, check hold
  task automatic run_block(input string tag, input logic [127:0] c,
                           input logic [127:0] exp, input int pulse_at);
    int n, lat, bsy;
    bus.cipher_text   = c;
    bus.data_valid_in = 1'b1;
    n = 0;
    while (!bus.data_ready_out && n < 100) begin tick(); n++; end
    check({tag, "_ready"}, 128'(bus.data_ready_out), 128'(1));
    tick();
    bus.data_valid_in = 1'b0;
    lat = 0; bsy = 0;
    while (!bus.data_valid_out && lat < 40) begin
      if (bus.data_ready_out) bsy++;
      if (lat == pulse_at) begin
        bus.key_valid_in = 1'b1;
        bus.round_keys   = alt_keys;
      end
      tick();
      lat++;
      bus.key_valid_in = 1'b0;
    end
    check({tag, "_latency"}, 128'(lat), 128'(14));
    check({tag, "_busy"}, 128'(bsy), 128'(0));
    check({tag, "_pt"}, bus.plain_text, exp);
    tick();
    check({tag, "_pulse"}, 128'(bus.data_valid_out), 128'(0));
    check({tag, "_hold"}, bus.plain_text, exp);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset             = 1'b0;
    bus.key_valid_in  = 1'b0;
    bus.round_keys    = '0;
    bus.data_valid_in = 1'b0;
    bus.cipher_text   = '0;
    build_sbox();
    keys_a = expand(FIPS_KEY);
    repeat (3) tick();
    check("rst_ready", 128'(bus.data_ready_out), 128'(0));
    check("rst_valid", 128'(bus.data_valid_out), 128'(0));
    check("rst_pt", bus.plain_text, 128'(0));
    reset = 1'b1;
    tick();

    // No key loaded yet: data must be refused
    bus.cipher_text   = FIPS_CT;
    bus.data_valid_in = 1'b1;
    cnt_r = 0; cnt_v = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.data_ready_out) cnt_r++;
      if (bus.data_valid_out) cnt_v++;
      tick();
    end
    check("nokey_ready", 128'(cnt_r), 128'(0));
    check("nokey_valid", 128'(cnt_v), 128'(0));
    check("nokey_pt", bus.plain_text, 128'(0));

    // Key load wins over simultaneous data
    bus.round_keys   = keys_a;
    bus.key_valid_in = 1'b1;
    #1;
    check("kv_ready_low", 128'(bus.data_ready_out), 128'(0));
    tick();
    bus.key_valid_in = 1'b0;
    #1;
    check("kv_no_accept", 128'(bus.data_ready_out), 128'(1));
    bus.data_valid_in = 1'b0;
    run_block("fips", FIPS_CT, FIPS_PT, -1);

    // Back-to-back with valid held high
    for (int i = 0; i < 3; i++) begin
      bb_pt[i] = {$urandom, $urandom, $urandom, $urandom};
      bb_ct[i] = encrypt(bb_pt[i], keys_a);
    end
    nacc = 0; nres = 0; busy = 0;
    bus.cipher_text   = bb_ct[0];
    bus.data_valid_in = 1'b1;
    for (int cyc = 0; cyc < 80 && nres < 3; cyc++) begin
      if (bus.data_valid_out) begin
        check($sformatf("b2b_pt%0d", nres), bus.plain_text, bb_pt[nres]);
        nres++;
      end
      if (bus.data_ready_out && !bus.data_valid_out && cyc > 0) busy++;
      if (bus.data_ready_out && bus.data_valid_in && nacc < 3) begin
        acc[nacc] = cyc;
        nacc++;
      end
      tick();
      if (nacc < 3) bus.cipher_text = bb_ct[nacc];
      else bus.data_valid_in = 1'b0;
    end
    bus.data_valid_in = 1'b0;
    check("b2b_accepts", 128'(nacc), 128'(3));
    check("b2b_results", 128'(nres), 128'(3));
    check("b2b_busy", 128'(busy), 128'(0));
    check("b2b_gap1", 128'(acc[1] - acc[0]), 128'(15));
    check("b2b_gap2", 128'(acc[2] - acc[1]), 128'(15));
    tick();

    // Key pulse mid-block is ignored; old key stays until reload
    alt_keys = expand({$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom});
    run_block("kchg", FIPS_CT, FIPS_PT, 5);
    pt_x = {$urandom, $urandom, $urandom, $urandom};
    run_block("kold", encrypt(pt_x, keys_a), pt_x, -1);
    load_key(alt_keys);
    pt_y = {$urandom, $urandom, $urandom, $urandom};
    run_block("knew", encrypt(pt_y, alt_keys), pt_y, -1);

    // Reset in the middle of a block
    bus.cipher_text   = encrypt(pt_x, alt_keys);
    bus.data_valid_in = 1'b1;
    check("rmid_ready", 128'(bus.data_ready_out), 128'(1));
    tick();
    bus.data_valid_in = 1'b0;
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    check("rmid_valid", 128'(bus.data_valid_out), 128'(0));
    check("rmid_pt", bus.plain_text, 128'(0));
    check("rmid_ready0", 128'(bus.data_ready_out), 128'(0));
    repeat (2) tick();
    reset = 1'b1;
    cnt_r = 0; cnt_v = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.data_ready_out) cnt_r++;
      if (bus.data_valid_out) cnt_v++;
      tick();
    end
    check("rpost_valid", 128'(cnt_v), 128'(0));
    check("rpost_ready", 128'(cnt_r), 128'(0));
    load_key(keys_a);
    run_block("rreload", FIPS_CT, FIPS_PT, -1);

    // Random round trips through the forward model
    for (int n = 0; n < 1000; n++) begin
      rk = expand({$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom});
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt, rk);
      load_key(rk);
      run_block("rt", ct, pt, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have parameter DATA_LEN, default 128, block width in bits.
REQ-002 SHALL have parameter NUMS_OF_ROUND, default 14, number of AES-256 rounds.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_valid_in, input, 1, qualifies round_keys for loading.
REQ-006 SHALL have port round_keys, input, (NUMS_OF_ROUND+1)*DATA_LEN, expanded schedule; key k at bits [128k+127:128k], k=0 is the initial AddRoundKey key, k=14 is the final-round key.
REQ-007 SHALL have port data_valid_in, input, 1, ciphertext valid.
REQ-008 SHALL have port data_ready_out, output, 1, block can accept ciphertext.
REQ-009 SHALL have port cipher_text, input, DATA_LEN, ciphertext block (FIPS-197 byte order, byte 0 = [127:120], column-major).
REQ-010 SHALL have port data_valid_out, output, 1, one-cycle result strobe.
REQ-011 SHALL have port plain_text, output, DATA_LEN, decrypted block, same byte order.

Function
REQ-012 SHALL implement the FIPS-197 AES-256 inverse cipher iteratively, one round per clock.
REQ-013 SHALL use FSM states IDLE, ROUND, LAST; reset state IDLE.
REQ-014 SHALL capture round_keys into an internal key register on the rising edge where key_valid_in=1 and state is IDLE, and set key_loaded=1.
REQ-015 SHALL ignore key_valid_in in ROUND and LAST; the running block uses the keys captured before its acceptance.
REQ-016 SHALL drive data_ready_out=1 only when state is IDLE, key_loaded=1, and key_valid_in=0.
REQ-017 SHALL accept a block on an edge with data_valid_in=1 and data_ready_out=1: state <= cipher_text XOR key14, round counter <= 13, FSM -> ROUND.
REQ-018 SHALL, in ROUND, each edge compute state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR key[cnt]) and decrement cnt; when cnt=1, FSM -> LAST.
REQ-019 SHALL, in LAST, compute plain_text <= InvSubBytes(InvShiftRows(state)) XOR key0, assert data_valid_out for exactly that following cycle, and return to IDLE.
REQ-020 SHALL give a fixed latency: data_valid_out high in the 14th cycle after the accepting edge; throughput is one block per 15 cycles.
REQ-021 SHALL hold plain_text stable after data_valid_out falls until the next result.
REQ-022 SHALL ignore data_valid_in when data_ready_out=0; there is no input buffering.
REQ-023 SHALL, when data_valid_in and key_valid_in are both 1 in IDLE, load the key and not accept data that cycle.

Reset
REQ-024 SHALL, on reset=0 at any time including mid-block, asynchronously clear the FSM to IDLE, the round counter, state and plain_text to 0, data_valid_out to 0, key_loaded to 0, and the key register to 0.
REQ-025 SHALL discard any in-flight block on reset and produce no data_valid_out for it after release.

Structure
REQ-026 SHALL place DATA_LEN and NUMS_OF_ROUND defaults, the inverse S-box table, and the GF(2^8) xtime and multiply-by-9/11/13/14 functions in the shared package aes_pkg.
REQ-027 SHALL use one combinational sub-module, inv_sbox (8-bit in, 8-bit out), instantiated 16 times and shared between ROUND and LAST.
REQ-028 SHALL register only the state, counter, FSM, key register, and outputs; the round datapath is combinational between registers.

Verification
REQ-029 SHALL verify FIPS-197 C.3: key 000102…1f schedule, ct 8ea2b7ca516745bfeafc49904b496089 -> plain_text 00112233445566778899aabbccddeeff, data_valid_out high exactly 14 cycles after accept, for 1 cycle.
REQ-030 SHALL verify back-to-back operation: data_valid_in held high with 3 blocks -> accepts spaced 15 cycles apart, 3 correct results, data_ready_out=0 while busy.
REQ-031 SHALL verify no key: data_valid_in=1 before any key_valid_in -> data_ready_out=0, no acceptance, no output.
REQ-032 SHALL verify key change mid-block: key_valid_in pulses with a new schedule during ROUND -> the current result is computed with the old key, and the next block still uses the old key until reloaded in IDLE.
REQ-033 SHALL verify reset mid-operation: reset=0 at round 7 -> all outputs 0 immediately, no data_valid_out after release, key must be reloaded before data_ready_out=1.
REQ-034 SHALL verify round trip: 1000 random key/plaintext pairs encrypted by the team's encryption pipeline and fed through this block -> plain_text equals the original every time.
